// File: rtl/imem_loader.sv
// Byte-stream program loader: packs big-endian bytes into 32-bit words for the imem write port and gates cpu_run.
// Latency: one WRITE cycle after every 4th accepted byte; done/cpu_run follow the last write (or checksum byte).
// Backpressure: byte_ready is high only in RECV (and CHECK); valid gaps stall indefinitely. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_run,
  output logic              checksum_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  // State entered after the final write (or directly for an empty load).
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHECK;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_idx, last_idx;
  logic [23:0]       shift;
  logic [ADDR_W:0]   n_clamp;
  logic              start_ok, byte_acc;

  assign n_clamp  = (word_count > DEPTH_L) ? DEPTH_L : word_count;
  assign start_ok = start && (state == S_IDLE || state == S_DONE);
  assign byte_acc = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (n_clamp == '0) ? S_TAIL : S_RECV;
      S_RECV:         if (byte_acc && byte_cnt == 2'd3) state_nxt = S_WRITE;
      S_WRITE:        state_nxt = (word_idx == last_idx) ? S_TAIL : S_RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK:        if (byte_acc) state_nxt = S_DONE;
`endif
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    cpu_run    = 1'b0;
    case (state)
      S_RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      S_WRITE: busy = 1'b1;
      S_DONE:  cpu_run = !checksum_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum          <= '0;
      checksum_err <= 1'b0;
    end else if (start_ok) begin
      sum          <= '0;
      checksum_err <= 1'b0;
    end else if (byte_acc && state == S_RECV) begin
      sum <= sum + byte_data;
    end else if (byte_acc && state == S_CHECK) begin
      checksum_err <= (sum + byte_data) != 8'h00;
    end
  end
`else
  assign checksum_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt   <= '0;
      word_idx   <= '0;
      last_idx   <= '0;
      shift      <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      // Pulse on entry, including a DONE -> DONE restart of an empty program.
      done    <= (state_nxt == S_DONE) && (state != S_DONE || start_ok);
      if (start_ok) begin
        byte_cnt <= '0;
        word_idx <= '0;
        // Wraps to DEPTH-1 when n == DEPTH; unused when n == 0.
        last_idx <= n_clamp[ADDR_W-1:0] - 1'b1;
      end
      if (state == S_RECV && byte_acc) begin
        shift    <= {shift[15:0], byte_data};
        byte_cnt <= byte_cnt + 1'b1;
        if (byte_cnt == 2'd3) begin
          imem_we    <= 1'b1;
          imem_waddr <= word_idx;
          imem_wdata <= {shift, byte_data};
        end
      end
      if (state == S_WRITE && word_idx != last_idx)
        word_idx <= word_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by stimulus, popped by a write monitor.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready, imem_we, busy, done, cpu_run, checksum_err;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .cpu_run(cpu_run), .checksum_err(checksum_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  tb_sum = '0;
  logic [31:0] prog [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every imem_we cycle must match the head of the scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, want no write", imem_waddr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("waddr", 32'(imem_waddr), 32'(e.addr));
          chk("wdata", imem_wdata, e.data);
          chk("cpu_run_in_write", 32'(cpu_run), 32'd0);
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input int pct);
    bit ok = 1'b0;
    for (int g = 0; g < 400 && !ok; g++) begin
      byte_valid = ($urandom_range(99) < pct);
      byte_data  = b;
      @(negedge clk);
      ok = byte_valid && byte_ready;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    if (ok) tb_sum = tb_sum + b;
    chk("byte_accept", 32'(ok), 32'd1);
  endtask

  task automatic do_start(input int wc);
    start      = 1'b1;
    word_count = wc[ADDR_W:0];
    @(posedge clk); #1;
    start  = 1'b0;
    tb_sum = '0;
  endtask

  task automatic send_word(input logic [31:0] w, input int pct, input logic [3:0] addr);
    exp_q.push_back(wr_t'{addr: addr, data: w});
    for (int k = 3; k >= 0; k--) push_byte(w[8*k +: 8], pct);
  endtask

  task automatic send_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_byte(8'h00 - tb_sum, 100);
`endif
  endtask

  task automatic wait_done(input int budget, input logic exp_run, input logic exp_err, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_cpu_run"}, 32'(cpu_run), 32'(exp_run));
      chk({tag, "_checksum_err"}, 32'(checksum_err), 32'(exp_err));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, "_cpu_run_held"}, 32'(cpu_run), 32'(exp_run));
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_imem_waddr"}, 32'(imem_waddr), 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_checksum_err"}, 32'(checksum_err), 32'd0);
  endtask

  initial begin
    int acc;
    prog[0] = 32'h20000001;
    prog[1] = 32'h00011020;
    prog[2] = 32'h8C220004;
    prog[3] = 32'hAC230008;
    for (int i = 4; i < 16; i++) prog[i] = {8'(i), 8'hA5, 8'(~i), 8'h3C};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Four words, byte_valid always high
    do_start(4);
    for (int i = 0; i < 4; i++) send_word(prog[i], 100, 4'(i));
    send_checksum();
    wait_done(10, 1'b1, 1'b0, "gapless");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("gapless_cpu_run_hold", 32'(cpu_run), 32'd1);
    end
    @(posedge clk); #1;

    // Sixteen words with 30% valid
    do_start(16);
    for (int i = 0; i < 16; i++) send_word(prog[i], 30, 4'(i));
    send_checksum();
    wait_done(10, 1'b1, 1'b0, "gappy");

    // word_count above DEPTH is clamped
    do_start(20);
    for (int i = 0; i < 16; i++) send_word(~prog[i], 100, 4'(i));
    send_checksum();
    wait_done(10, 1'b1, 1'b0, "clamp");
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'(i);
      @(negedge clk);
      if (byte_ready) acc++;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    chk("clamp_extra_accepts", 32'(acc), 32'd0);

    // Empty program
    do_start(0);
    send_checksum();
    wait_done(2, 1'b1, 1'b0, "zero");

    // Reset after 2 of 3 words
    do_start(3);
    send_word(prog[4], 100, 4'd0);
    send_word(prog[5], 100, 4'd1);
    @(negedge clk);
    chk("abort_two_written", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    push_byte(8'h11, 100);
    push_byte(8'h22, 100);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    @(posedge clk); #1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'h33;
      @(negedge clk);
      if (byte_ready) acc++;
      chk("abort_cpu_run_low", 32'(cpu_run), 32'd0);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    chk("abort_no_accepts", 32'(acc), 32'd0);
    do_start(1);
    send_word(prog[6], 100, 4'd0);
    send_checksum();
    wait_done(10, 1'b1, 1'b0, "reload");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum pass then fail on 01 02 03 04
    do_start(1);
    send_word(32'h01020304, 100, 4'd0);
    push_byte(8'hF6, 100);
    wait_done(10, 1'b1, 1'b0, "cks_good");
    do_start(1);
    send_word(32'h01020304, 100, 4'd0);
    push_byte(8'hF7, 100);
    wait_done(10, 1'b0, 1'b1, "cks_bad");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cks_err_hold", 32'(checksum_err), 32'd1);
      chk("cks_err_cpu_run", 32'(cpu_run), 32'd0);
    end
    @(posedge clk); #1;
    do_start(0);
    @(negedge clk);
    chk("cks_err_cleared", 32'(checksum_err), 32'd0);
    @(posedge clk); #1;
    push_byte(8'h00, 100);
    wait_done(10, 1'b1, 1'b0, "cks_zero");
`endif

    @(negedge clk);
    chk("final_pending_writes", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
